snake_step_sequencer: RTL

//  Game-step scheduler for the snake datapath. A free-running tick timer paces each step.
//  Per tick it sequences: advance snake (step_req/step_done), await collision/food verdict,

---
 rtl/snake_pkg.sv | 22 ++
 rtl/snake_tick_timer.sv | 30 +++
 rtl/snake_step_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: shared state encoding, default timing constants and helpers for the snake step sequencer
//   state_t          sequencer states (3-bit)
//   *_DEF            default tick period, floor, speed-up step and register widths
//   is_playing()     true in the states where the tick timer may run
package snake_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_STEP,
        S_CHECK,
        S_DRAW,
        S_OVER
    } state_t;
    localparam int TICK_CYCLES_DEF  = 5000000;
    localparam int MIN_TICK_DEF     = 1000000;
    localparam int SPEEDUP_STEP_DEF = 250000;
    localparam int CNT_WIDTH_DEF    = 23;
    localparam int SCORE_WIDTH_DEF  = 8;
    function automatic logic is_playing(input state_t s);
        return s inside {S_WAIT_TICK, S_STEP, S_CHECK, S_DRAW};
    endfunction
endpackage

// File: rtl/snake_tick_timer.sv
// snake_tick_timer: programmable-period tick counter with run gate, load and expire pulse
//   clock, reset   system clock, asynchronous active-high reset
//   run_i          count enable (low while paused or not playing)
//   load_i         restart the count from zero
//   period_i       tick period in cycles
//   expire_o       high in the last cycle of each period while running
module snake_tick_timer
    import snake_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 run_i,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] period_i,
    output logic                 expire_o
);
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
    logic [CNT_WIDTH-1:0] count_q, count_d;
    // >= rather than == so a period shortened below the running count still expires
    always_comb begin
        expire_o = run_i && (count_q >= period_i - ONE);
        count_d  = load_i ? '0 : !run_i ? count_q : expire_o ? '0 : count_q + ONE;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end
endmodule

// File: rtl/snake_step_sequencer.sv
// snake_step_sequencer: per-tick game-step scheduler (step, verdict, score/speed, redraw)
//   clock, reset                 system clock, asynchronous active-high reset
//   start                        begins a new game from IDLE or OVER
//   pause                        freezes the tick timer only
//   step_done / step_req         snake engine advance handshake
//   collide_valid, collision,
//   food_eaten                   verdict for the step just taken
//   draw_ack / draw_req          display redraw handshake
//   grow                         lengthen snake by one segment
//   score                        saturating food count
//   playing, game_over, overrun  status flags
module snake_step_sequencer
    import snake_pkg::*;
#(
    parameter int TICK_CYCLES  = TICK_CYCLES_DEF,
    parameter int MIN_TICK     = MIN_TICK_DEF,
    parameter int SPEEDUP_STEP = SPEEDUP_STEP_DEF,
    parameter int CNT_WIDTH    = CNT_WIDTH_DEF,
    parameter int SCORE_WIDTH  = SCORE_WIDTH_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   pause,
    input  logic                   step_done,
    input  logic                   collide_valid,
    input  logic                   collision,
    input  logic                   food_eaten,
    input  logic                   draw_ack,
    output logic                   step_req,
    output logic                   grow,
    output logic                   draw_req,
    output logic [SCORE_WIDTH-1:0] score,
    output logic                   playing,
    output logic                   game_over,
    output logic                   overrun
);
    localparam logic [CNT_WIDTH-1:0]   TICK      = CNT_WIDTH'(TICK_CYCLES);
    localparam logic [CNT_WIDTH-1:0]   MIN       = CNT_WIDTH'(MIN_TICK);
    localparam logic [CNT_WIDTH-1:0]   STEP      = CNT_WIDTH'(SPEEDUP_STEP);
    localparam logic [CNT_WIDTH-1:0]   MIN_PLUS  = CNT_WIDTH'(MIN_TICK + SPEEDUP_STEP);
    localparam logic [SCORE_WIDTH-1:0] SCORE_ONE = SCORE_WIDTH'(1);
    state_t               state_q;
    logic [CNT_WIDTH-1:0] period_q;
    logic                 tick_pending_q;
    logic                 expire, start_ok, consume;
    assign start_ok = start && (state_q == S_IDLE || state_q == S_OVER);
    // an expiry in WAIT_TICK is consumed directly, never parked in the pend flag
    assign consume  = (state_q == S_WAIT_TICK) && (tick_pending_q || expire);
    snake_tick_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .run_i    (is_playing(state_q) && !pause),
        .load_i   (start_ok),
        .period_i (period_q),
        .expire_o (expire)
    );
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            period_q       <= TICK;
            tick_pending_q <= 1'b0;
            step_req       <= 1'b0;
            grow           <= 1'b0;
            draw_req       <= 1'b0;
            score          <= '0;
            playing        <= 1'b0;
            game_over      <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            step_req       <= 1'b0;
            grow           <= 1'b0;
            tick_pending_q <= !consume && (tick_pending_q || expire);
            if (expire && tick_pending_q) overrun <= 1'b1;
            case (state_q)
                S_IDLE, S_OVER: if (start) begin
                    state_q        <= S_WAIT_TICK;
                    period_q       <= TICK;
                    tick_pending_q <= 1'b0;
                    score          <= '0;
                    overrun        <= 1'b0;
                    playing        <= 1'b1;
                    game_over      <= 1'b0;
                end
                S_WAIT_TICK: if (consume) begin
                    state_q  <= S_STEP;
                    step_req <= 1'b1;
                end
                S_STEP: if (step_done) state_q <= S_CHECK;
                S_CHECK: if (collide_valid) begin
                    if (collision) begin
                        state_q   <= S_OVER;
                        playing   <= 1'b0;
                        game_over <= 1'b1;
                    end else begin
                        if (food_eaten) begin
                            grow     <= 1'b1;
                            score    <= &score ? score : score + SCORE_ONE;
                            period_q <= (period_q >= MIN_PLUS) ? period_q - STEP : MIN;
                        end
                        state_q  <= S_DRAW;
                        draw_req <= 1'b1;
                    end
                end
                S_DRAW: if (draw_ack) begin
                    state_q  <= S_WAIT_TICK;
                    draw_req <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
